// File: rtl/multi_cycle_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/OR/SUBP plus bit-serial
// CMCO (longest ones run), POPC and MULU (shift-add).
module multi_cycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AO,
    output logic [WIDTH-1:0] HI,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_CMCO = 4'd3;
    localparam logic [3:0] OP_SUBP = 4'd4;
    localparam logic [3:0] OP_POPC = 4'd5;
    localparam logic [3:0] OP_MULU = 4'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] bq;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  run;
    logic [CNTW-1:0]  best;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] sc_ao;
    logic             sc_ovf;
    logic             iter;

    always_comb begin
        sc_ao  = '0;
        sc_ovf = 1'b0;
        iter   = 1'b0;
        sum    = A + B;
        dif    = A - B;
        case (ALUop)
            OP_ADD: begin
                sc_ao  = sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                         (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_ao  = dif;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                         (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_OR:   sc_ao = A | B;
            OP_SUBP: sc_ao = ($signed(A) > $signed(B)) ? dif : (B - A);
            OP_CMCO, OP_POPC, OP_MULU: iter = 1'b1;
            default: ;
        endcase
    end

    // One serial step: sa shifts right; for MULU its top refills
    // with product bits so {acc, sa} ends as the full product.
    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] sa_nx;
    logic [CNTW-1:0]  run_nx;
    logic [CNTW-1:0]  best_nx;
    logic [CNTW-1:0]  pop_nx;

    always_comb begin
        madd    = {1'b0, acc} + (sa[0] ? {1'b0, bq} : '0);
        sa_nx   = (op == OP_MULU) ? {madd[0], sa[WIDTH-1:1]}
                                  : {1'b0, sa[WIDTH-1:1]};
        run_nx  = sa[0] ? (run + CNTW'(1)) : '0;
        best_nx = (run_nx > best) ? run_nx : best;
        pop_nx  = best + {{(CNTW-1){1'b0}}, sa[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op    <= '0;
            sa    <= '0;
            bq    <= '0;
            acc   <= '0;
            cnt   <= '0;
            run   <= '0;
            best  <= '0;
            AO    <= '0;
            HI    <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op   <= ALUop;
                        sa   <= A;
                        bq   <= B;
                        acc  <= '0;
                        cnt  <= '0;
                        run  <= '0;
                        best <= '0;
                        if (iter) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            AO    <= sc_ao;
                            HI    <= '0;
                            ovf   <= sc_ovf;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    cnt  <= cnt + CNTW'(1);
                    sa   <= sa_nx;
                    acc  <= madd[WIDTH:1];
                    run  <= run_nx;
                    best <= (op == OP_POPC) ? pop_nx : best_nx;
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ovf   <= 1'b0;
                        case (op)
                            OP_MULU: begin
                                AO <= sa_nx;
                                HI <= madd[WIDTH:1];
                            end
                            OP_POPC: begin
                                AO <= WIDTH'(pop_nx);
                                HI <= '0;
                            end
                            default: begin
                                AO <= WIDTH'(best_nx);
                                HI <= '0;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed bench for multi_cycle_alu: vector table plus
// hand sequences for ignored start, back-to-back and reset abort.
module tb_multi_cycle_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUop;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] AO;
    logic [31:0] HI;
    logic        ovf;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    multi_cycle_alu #(.WIDTH(32), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ALUop (ALUop),
        .A     (A),
        .B     (B),
        .AO    (AO),
        .HI    (HI),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ao;
        logic [31:0] hi;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bcnt;
        logic [31:0] ao_s;
        start = 1'b1;
        ALUop = v.op;
        A     = v.a;
        B     = v.b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        lat   = 0;
        bcnt  = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d busy", idx), 64'(bcnt), 64'(v.lat - 1));
        chk($sformatf("v%0d AO", idx), 64'(AO), 64'(v.ao));
        chk($sformatf("v%0d HI", idx), 64'(HI), 64'(v.hi));
        chk($sformatf("v%0d ovf", idx), 64'(ovf), 64'(v.ovf));
        ao_s = AO;
        @(negedge clk);
        chk($sformatf("v%0d done pulse", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d AO hold", idx), 64'(AO), 64'(ao_s));
    endtask

    initial begin
        int ndone;
        int first;
        vec_t v;

        vecs.push_back('{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1});
        vecs.push_back('{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1});
        vecs.push_back('{4'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd2, 32'h0000F0F0, 32'h000F0F00, 32'h000FFFF0, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd4, 32'hFFFFFFFB, 32'h00000003, 32'h00000008, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd4, 32'h00000003, 32'hFFFFFFFB, 32'h00000008, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd4, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd7, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd15, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1});
        vecs.push_back('{4'd3, 32'hF0FF0E07, 32'h12345678, 32'h00000008, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd3, 32'hFFFFFFFF, 32'h00000000, 32'h00000020, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd3, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd3, 32'h80000001, 32'h00000000, 32'h00000001, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd3, 32'h7FFFFFFE, 32'h00000000, 32'h0000001E, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd6, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1, 1'b0, 33});
        vecs.push_back('{4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33});
        vecs.push_back('{4'd6, 32'h12345678, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd6, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 1'b0, 33});
        vecs.push_back('{4'd5, 32'hFFFFFFFF, 32'h00000000, 32'h00000020, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd5, 32'h0000000F, 32'hDEADBEEF, 32'h00000004, 32'h0, 1'b0, 33});
        vecs.push_back('{4'd5, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0, 33});

        reset = 1'b0;
        start = 1'b0;
        ALUop = 4'd0;
        A     = 32'h0;
        B     = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset AO", 64'(AO), 64'd0);
        chk("reset HI", 64'(HI), 64'd0);
        chk("reset flags", 64'({ovf, busy, done}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Back-to-back: new start accepted in the DONE cycle.
        start = 1'b1; ALUop = 4'd0; A = 32'd20; B = 32'd22;
        @(posedge clk);
        #1;
        ALUop = 4'd1; A = 32'd10; B = 32'd3;
        @(negedge clk);
        chk("b2b first done", 64'(done), 64'd1);
        chk("b2b first AO", 64'(AO), 64'd42);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b second done", 64'(done), 64'd1);
        chk("b2b second AO", 64'(AO), 64'd7);
        @(negedge clk);
        chk("b2b idle", 64'(done), 64'd0);

        // ADD start in cycle 10 of a MULU run must be ignored.
        start = 1'b1; ALUop = 4'd6; A = 32'hFFFFFFFF; B = 32'h2;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = k;
                    chk("ign AO", 64'(AO), 64'hFFFFFFFE);
                    chk("ign HI", 64'(HI), 64'h1);
                end
            end
            if (k == 10) begin
                start = 1'b1; ALUop = 4'd0;
                A = 32'h1; B = 32'h1;
            end
        end
        chk("ign done cycle", 64'(first), 64'd33);
        chk("ign done count", 64'(ndone), 64'd1);

        // Reset in cycle 15 of CMCO aborts with no done.
        start = 1'b1; ALUop = 4'd3; A = 32'hF0FF0E07; B = 32'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort busy before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort AO", 64'(AO), 64'd0);
        chk("abort HI", 64'(HI), 64'd0);
        chk("abort flags", 64'({ovf, busy, done}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);

        // Start coincident with reset release: first edge accepts.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        v = '{4'd5, 32'h0000000F, 32'hFFFF0000, 32'h00000004, 32'h0, 1'b0, 33};
        run_vec(v, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
